inst_fetch_unit: RTL
====================

# inst_fetch_unit

Front-end fetch sequencer that drives the PC into the instruction memory and collects the returned instruction bundles. The memory read path is combinational and returns FETCH_WIDTH 32-bit words per PC. The block owns the PC register and buffers fetched bundles in a small FIFO (the fetch queue). It hands bundles to decode over a valid/ready handshake and handles redirects from the back end by flushing the queue.

## Interface
- INST_ADDR_WIDTH, default `INST_ADDR_WIDTH: byte-address width of the instruction memory.
- FETCH_WIDTH, default `FETCH_WIDTH: number of instructions per bundle; must be ≥1.
- QUEUE_DEPTH, default 4: number of bundle entries in the fetch queue; must be a power of 2 and ≥2.
- RESET_PC, default 0: PC value loaded on reset; must be 4-byte aligned.

Ports (clock and reset first):
- clk, input, 1: the block's single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- fetch_en_i, input, 1: when 0, no new bundles are captured and the PC holds.
- pc_o, output, INST_ADDR_WIDTH: PC presented to the instruction memory; driven directly from the PC register.
- instruction_code_i, input, 32 x [FETCH_WIDTH]: combinational memory response for pc_o; element i is the word at pc_o+4*i.
- redirect_valid_i, input, 1: back-end redirect request.
- redirect_pc_i, input, INST_ADDR_WIDTH: redirect target; bits [1:0] are ignored and treated as 0.
- bundle_valid_o, output, 1: the queue head holds a valid bundle.
- bundle_pc_o, output, INST_ADDR_WIDTH: PC of the head bundle's element 0.
- bundle_inst_o, output, 32 x [FETCH_WIDTH]: instructions of the head bundle.
- bundle_ready_i, input, 1: decode accepts the head bundle.
- queue_count_o, output, $clog2(QUEUE_DEPTH)+1: number of valid entries in the queue.

## Operation
- Definitions:
  - pop = bundle_valid_o & bundle_ready_i.
  - push = fetch_en_i & !redirect_valid_i & (count < QUEUE_DEPTH | pop).
- On push, the entry {pc_o, instruction_code_i} is written at the tail, and the PC becomes pc_o + 4*FETCH_WIDTH, modulo 2^INST_ADDR_WIDTH (wrap-around is silent).
- On pop, the head advances.
- If push and pop occur together:
  - count is unchanged.
  - When the queue is full, the push is allowed (pass-through of the freed slot).
- Redirect has the highest priority:
  - All entries are flushed and count becomes 0.
  - The PC becomes {redirect_pc_i[INST_ADDR_WIDTH-1:2], 2'b00}.
  - Any concurrent pop and push are discarded.
- When not pushing, the PC holds. This covers fetch_en_i=0, or a full queue with no pop.
- The queue is a circular buffer with head and tail pointers of $clog2(QUEUE_DEPTH) bits that wrap naturally.
- Empty queue: bundle_valid_o=0. bundle_pc_o and bundle_inst_o are don't-care when invalid, but must be stable while valid and not popped.
- The block does not modify instruction contents, and there is no misalignment fault. Memory words outside the loaded image are passed through as returned.

## Timing
- Reset, asynchronous, forces:
  - pc_o=RESET_PC.
  - bundle_valid_o=0, queue_count_o=0.
  - bundle_pc_o=0 and all bundle_inst_o elements=0.
  - head and tail pointers = 0.
- No push occurs while reset is high; the memory image loads during reset.
- Reset asserted mid-operation discards all queued bundles immediately, without waiting for a clock edge.
- Fetch latency:
  - pc_o is sampled together with instruction_code_i at the edge ending cycle N.
  - The bundle is visible at the queue output from cycle N+1.
  - When the queue was empty, bundle_valid_o=1 in cycle N+1.
- Throughput: one bundle per cycle when decode is always ready.
- Redirect in cycle N:
  - pc_o equals the target in cycle N+1.
  - bundle_valid_o=0 in cycle N+1.
  - The first target bundle is valid in cycle N+2.
- queue_count_o and bundle_valid_o are registered outputs; there is no combinational path from any input to them.
- bundle_ready_i may be asserted while bundle_valid_o=0; this has no effect.

## Test plan
Default parameters for all scenarios: FETCH_WIDTH=2, QUEUE_DEPTH=4, RESET_PC=0, INST_ADDR_WIDTH=10.

1. Reset released with fetch_en_i=1 and bundle_ready_i=1 -> pc_o steps 0, 8, 0x10, 0x18. Bundles arrive one per cycle from the first cycle after release, with bundle_pc_o=0 and bundle_inst_o = {mem word @4, mem word @0}.
2. bundle_ready_i=0 for 6 cycles -> queue_count_o climbs to 4 and pc_o freezes at 0x20. Then ready=1 -> bundles with PCs 0, 8, 0x10, 0x18, 0x20 are delivered in order with no gap.
3. Full queue with pop and push in the same cycle -> count stays 4 and pc_o advances by 8.
4. Redirect to 0x103 while 3 bundles are queued and ready=1 -> next cycle count=0, valid=0, pc_o=0x100. The following cycle bundle_pc_o=0x100. No stale bundle is ever delivered.
5. Fetch from pc=0x3F8 -> the next pc_o is 0x000 (wrap). The bundle at 0x3F8 is delivered intact.
6. reset asserted asynchronously between edges with 2 bundles queued -> valid=0, count=0 and pc_o=0 immediately. After release, fetch restarts at 0.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, captures combinational memory
// bundles into a circular fetch queue and hands them to decode via valid/ready.
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 2
`endif

module inst_fetch_unit #(
  parameter int unsigned INST_ADDR_WIDTH = `INST_ADDR_WIDTH,
  parameter int unsigned FETCH_WIDTH     = `FETCH_WIDTH,
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                fetch_en_i,
  output logic [INST_ADDR_WIDTH-1:0]          pc_o,
  input  logic [FETCH_WIDTH-1:0][31:0]        instruction_code_i,
  input  logic                                redirect_valid_i,
  input  logic [INST_ADDR_WIDTH-1:0]          redirect_pc_i,
  output logic                                bundle_valid_o,
  output logic [INST_ADDR_WIDTH-1:0]          bundle_pc_o,
  output logic [FETCH_WIDTH-1:0][31:0]        bundle_inst_o,
  input  logic                                bundle_ready_i,
  output logic [$clog2(QUEUE_DEPTH):0]        queue_count_o
);

  localparam int unsigned PW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [INST_ADDR_WIDTH-1:0]   pc_q;
  logic [PW-1:0]                head_q, tail_q;
  logic [CW-1:0]                count_q;
  logic [INST_ADDR_WIDTH-1:0]   q_pc   [QUEUE_DEPTH];
  logic [FETCH_WIDTH-1:0][31:0] q_inst [QUEUE_DEPTH];

  logic pop, push;

  // Valid is derived from the count register only, so no input reaches it.
  assign bundle_valid_o = (count_q != '0);
  assign queue_count_o  = count_q;
  assign pc_o           = pc_q;
  assign bundle_pc_o    = q_pc[head_q];
  assign bundle_inst_o  = q_inst[head_q];

  always_comb begin
    pop  = bundle_valid_o & bundle_ready_i;
    push = fetch_en_i & ~redirect_valid_i & ((count_q < CW'(QUEUE_DEPTH)) | pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        q_pc[i]   <= '0;
        q_inst[i] <= '0;
      end
    end else if (redirect_valid_i) begin
      // Redirect wins over any same-cycle push or pop.
      pc_q    <= redirect_pc_i & ~INST_ADDR_WIDTH'(3);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        q_pc[tail_q]   <= pc_q;
        q_inst[tail_q] <= instruction_code_i;
        tail_q         <= tail_q + PW'(1);
        pc_q           <= pc_q + INST_ADDR_WIDTH'(4 * FETCH_WIDTH);
      end
      if (pop) begin
        head_q <= head_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
